// File: rtl/sm_div_pkg.sv
// Shared definitions for the sign-magnitude fixed-point number format and the
// sequential divider state machine.
package sm_div_pkg;

   localparam int unsigned SM_SIZE     = 16;
   localparam int unsigned SM_FRAC     = 8;
   localparam int unsigned SM_SIGN_BIT = SM_SIZE - 1;

   // All-ones magnitude: the largest representable value, used when clamping.
   localparam logic [SM_SIZE-2:0] SM_MAX_MAG   = '1;
   localparam logic [SM_SIZE-1:0] SM_SATURATED = '1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/sm_div.sv
// Sequential sign-magnitude fixed-point divider (restoring, one quotient bit
// per clock). Magnitude result = floor((|a| << FRAC) / |b|), clamped to the
// all-ones magnitude on overflow; divide by zero returns a saturated result.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid / in_ready  operand handshake (a, b sign-magnitude)
//   out_valid / out_ready result handshake (q sign-magnitude, sat, dbz)
module sm_div
   import sm_div_pkg::*;
#(
   parameter int unsigned SIZE = SM_SIZE,
   parameter int unsigned FRAC = SM_FRAC
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [SIZE-1:0] a,
   input  logic [SIZE-1:0] b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [SIZE-1:0] q,
   output logic            sat,
   output logic            dbz
);

   localparam int unsigned MW = SIZE - 1;
   localparam int unsigned W  = MW + FRAC;
   localparam int unsigned CW = $clog2(W + 1);

   state_t          state_q, state_d;
   logic [W-1:0]    dvd_q, dvd_d;
   logic [SIZE-1:0] rem_q, rem_d;
   logic [W-1:0]    quo_q, quo_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [MW-1:0]   div_q, div_d;
   logic            sign_q, sign_d;
   logic            in_ready_d, out_valid_d, sat_d, dbz_d;
   logic [SIZE-1:0] q_d;

   // One restoring-division step on the current remainder.
   logic [SIZE:0]   rem_sh;
   logic [SIZE-1:0] rem_sub;
   logic [SIZE-1:0] rem_nx;
   logic            qbit;
   logic [W-1:0]    quo_nx;
   logic            ovf;
   logic [MW-1:0]   mag;
   logic            sign_out;

   always_comb begin
      rem_sh   = {rem_q, dvd_q[W-1]};
      qbit     = (rem_sh >= {2'b00, div_q});
      // rem_sh < 2*|b| so the subtraction result always fits SIZE bits.
      rem_sub  = rem_sh[SIZE-1:0] - {1'b0, div_q};
      rem_nx   = qbit ? rem_sub : rem_sh[SIZE-1:0];
      quo_nx   = {quo_q[W-2:0], qbit};
      ovf      = (|quo_nx[W-1:MW]) | quo_q[W-1];
      mag      = ovf ? {MW{1'b1}} : quo_nx[MW-1:0];
      // Zero results never carry a negative sign.
      sign_out = sign_q & (|mag);
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d     = state_q;
      dvd_d       = dvd_q;
      rem_d       = rem_q;
      quo_d       = quo_q;
      cnt_d       = cnt_q;
      div_d       = div_q;
      sign_d      = sign_q;
      in_ready_d  = in_ready;
      out_valid_d = out_valid;
      q_d         = q;
      sat_d       = sat;
      dbz_d       = dbz;

      unique case (state_q)
         IDLE: begin
            if (in_valid && in_ready) begin
               div_d      = b[MW-1:0];
               sign_d     = a[SIZE-1] ^ b[SIZE-1];
               in_ready_d = 1'b0;
               if (b[MW-1:0] == '0) begin
                  // A negative-zero divisor is still zero.
                  state_d     = DONE;
                  out_valid_d = 1'b1;
                  q_d         = {a[SIZE-1], {MW{1'b1}}};
                  sat_d       = 1'b1;
                  dbz_d       = 1'b1;
               end else begin
                  state_d = RUN;
                  dvd_d   = {a[MW-1:0], {FRAC{1'b0}}};
                  rem_d   = '0;
                  quo_d   = '0;
                  cnt_d   = CW'(W);
               end
            end
         end

         RUN: begin
            dvd_d = {dvd_q[W-2:0], 1'b0};
            rem_d = rem_nx;
            quo_d = quo_nx;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d     = DONE;
               out_valid_d = 1'b1;
               q_d         = {sign_out, mag};
               sat_d       = ovf;
               dbz_d       = 1'b0;
            end
         end

         DONE: begin
            if (out_valid && out_ready) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
            end
         end

         default: begin
            state_d     = IDLE;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
         end
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         dvd_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         cnt_q     <= '0;
         div_q     <= '0;
         sign_q    <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         q         <= '0;
         sat       <= 1'b0;
         dbz       <= 1'b0;
      end else begin
         state_q   <= state_d;
         dvd_q     <= dvd_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         cnt_q     <= cnt_d;
         div_q     <= div_d;
         sign_q    <= sign_d;
         in_ready  <= in_ready_d;
         out_valid <= out_valid_d;
         q         <= q_d;
         sat       <= sat_d;
         dbz       <= dbz_d;
      end
   end

endmodule
